// File: rtl/lsu_wb_stage.sv
// lsu_wb_stage
//   Load/store + writeback stage of the RV32I three-stage pipeline. Takes one op
//   per in_valid/in_ready handshake from the EX->LSWB register and latches it. For
//   loads and stores it issues one request on a valid/ready data bus and waits for
//   the response. It then aligns and extends load data and writes the register file.
//   Misaligned accesses, illegal funct3 codes and bus timeouts retire the op with err
//   and perform no register write.
//
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   in_valid / in_ready          op handshake (ready only in IDLE)
//   in_mem_ren / in_mem_wen      load / store op
//   in_R_wen, in_rd              op writes rd
//   in_funct3                    access size / signedness
//   in_ex_result                 writeback value (non-mem) or byte address (mem)
//   in_rs2_value, in_pc          store data, op PC
//   mem_req_*                    bus request (word address, lane-replicated data, strobes)
//   mem_rsp_valid/_rdata         bus response (read data or write ack)
//   rf_wen/_waddr/_wdata         register file write port
//   wb_done, wb_pc, err          retire pulse, retiring PC, error flag
//
// state | meaning
// IDLE  | waiting for an op, in_ready=1
// REQ   | bus request presented, waiting for mem_req_ready
// RESP  | request accepted, waiting for mem_rsp_valid
// WB    | retire: wb_done pulse, register file write

module lsu_wb_stage #(
    parameter int BUS_TIMEOUT = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mem_ren,
    input  logic        in_mem_wen,
    input  logic        in_R_wen,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_ex_result,
    input  logic [31:0] in_rs2_value,
    input  logic [31:0] in_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_done,
    output logic [31:0] wb_pc,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Counter only needs to reach BUS_TIMEOUT-1; the terminal cycle is detected
    // by compare rather than by counting one further.
    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam bit TIMEOUT_EN = (BUS_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    state_t state, state_nxt;

    logic             op_ren;
    logic             op_wen;
    logic             op_rwen;
    logic [4:0]       op_rd;
    logic [2:0]       op_f3;
    logic [31:0]      op_ex;
    logic [31:0]      op_rs2;
    logic [31:0]      op_pc;
    logic             op_err;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt;

    logic        accept;
    logic        in_mem;
    logic        in_bad;
    logic        timeout_hit;
    logic [31:0] rdata_shift;
    logic [31:0] load_data;

    function automatic logic access_bad(input logic ren, input logic wen,
                                        input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        logic misaligned;
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (ren) begin
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end else if (wen) begin
            illegal = (f3 > 3'b010);
        end
        // funct3[1:0] is the size for both loads and stores (LBU/LHU share it).
        if (ren || wen) begin
            misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                         ((f3[1:0] == 2'b10) && (a != 2'b00));
        end
        return illegal || misaligned;
    endfunction

    assign accept      = in_valid && (state == S_IDLE);
    assign in_mem      = in_mem_ren || in_mem_wen;
    assign in_bad      = access_bad(in_mem_ren, in_mem_wen, in_funct3, in_ex_result[1:0]);
    assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (in_mem && !in_bad) ? S_REQ : S_WB;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_nxt = S_RESP;
                end else if (timeout_hit) begin
                    state_nxt = S_WB;
                end
            end
            S_RESP: begin
                // A response in the same cycle as the timeout still completes the op.
                if (mem_rsp_valid || timeout_hit) begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_ren  <= 1'b0;
            op_wen  <= 1'b0;
            op_rwen <= 1'b0;
            op_rd   <= 5'd0;
            op_f3   <= 3'd0;
            op_ex   <= 32'd0;
            op_rs2  <= 32'd0;
            op_pc   <= 32'd0;
            op_err  <= 1'b0;
            rdata_q <= 32'd0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        op_ren  <= in_mem_ren;
                        op_wen  <= in_mem_wen;
                        op_rwen <= in_R_wen;
                        op_rd   <= in_rd;
                        op_f3   <= in_funct3;
                        op_ex   <= in_ex_result;
                        op_rs2  <= in_rs2_value;
                        op_pc   <= in_pc;
                        op_err  <= in_mem && in_bad;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        cnt <= '0;
                    end else if (timeout_hit) begin
                        cnt    <= '0;
                        op_err <= 1'b1;
                    end else if (TIMEOUT_EN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (mem_rsp_valid) begin
                        cnt     <= '0;
                        rdata_q <= mem_rsp_rdata;
                    end else if (timeout_hit) begin
                        cnt    <= '0;
                        op_err <= 1'b1;
                    end else if (TIMEOUT_EN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Bring the addressed byte/half down to bit 0; legal halves have a[0]=0,
    // so the same byte-granular shift serves both sizes.
    assign rdata_shift = rdata_q >> {op_ex[1:0], 3'b000};

    always_comb begin
        case (op_f3)
            3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_data = {24'd0, rdata_shift[7:0]};
            3'b101:  load_data = {16'd0, rdata_shift[15:0]};
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        in_ready      = (state == S_IDLE);
        mem_req_valid = 1'b0;
        mem_req_addr  = 32'd0;
        mem_req_wen   = 1'b0;
        mem_req_wdata = 32'd0;
        mem_req_wstrb = 4'd0;
        rf_wen        = 1'b0;
        rf_waddr      = 5'd0;
        rf_wdata      = 32'd0;
        wb_done       = 1'b0;
        wb_pc         = 32'd0;
        err           = 1'b0;

        if (state == S_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {op_ex[31:2], 2'b00};
            mem_req_wen   = op_wen;
            if (op_wen) begin
                case (op_f3)
                    3'b000: begin
                        mem_req_wdata = {4{op_rs2[7:0]}};
                        mem_req_wstrb = 4'b0001 << op_ex[1:0];
                    end
                    3'b001: begin
                        mem_req_wdata = {2{op_rs2[15:0]}};
                        mem_req_wstrb = 4'b0011 << op_ex[1:0];
                    end
                    default: begin
                        mem_req_wdata = op_rs2;
                        mem_req_wstrb = 4'b1111;
                    end
                endcase
            end
        end

        if (state == S_WB) begin
            wb_done  = 1'b1;
            wb_pc    = op_pc;
            err      = op_err;
            rf_wen   = op_rwen && (op_rd != 5'd0) && !op_err;
            rf_waddr = op_rd;
            rf_wdata = op_ren ? load_data : op_ex;
        end
    end

endmodule

// File: tb/tb_lsu_wb_stage.sv
module tb_lsu_wb_stage;

    localparam int T = 4;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_mem_ren;
    logic        in_mem_wen;
    logic        in_R_wen;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [31:0] in_ex_result;
    logic [31:0] in_rs2_value;
    logic [31:0] in_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_done;
    logic [31:0] wb_pc;
    logic        err;

    int n_checks = 0;
    int n_errs   = 0;

    lsu_wb_stage #(.BUS_TIMEOUT(T)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mem_ren    (in_mem_ren),
        .in_mem_wen    (in_mem_wen),
        .in_R_wen      (in_R_wen),
        .in_rd         (in_rd),
        .in_funct3     (in_funct3),
        .in_ex_result  (in_ex_result),
        .in_rs2_value  (in_rs2_value),
        .in_pc         (in_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .wb_done       (wb_done),
        .wb_pc         (wb_pc),
        .err           (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic scramble_inputs();
        in_mem_ren   = 1'($urandom);
        in_mem_wen   = ~in_mem_ren & 1'($urandom);
        in_R_wen     = 1'($urandom);
        in_rd        = 5'($urandom);
        in_funct3    = 3'($urandom);
        in_ex_result = $urandom;
        in_rs2_value = $urandom;
        in_pc        = $urandom;
    endtask

    // Reference: RV32I load extraction from the addressed lane.
    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] word);
        logic [31:0] lane;
        logic [31:0] r;
        lane = word >> (8 * a);
        case (f3)
            3'd0: begin r = lane & 32'hFF;   if (r[7])  r = r | 32'hFFFF_FF00; end
            3'd1: begin r = lane & 32'hFFFF; if (r[15]) r = r | 32'hFFFF_0000; end
            3'd4: r = lane & 32'hFF;
            3'd5: r = lane & 32'hFFFF;
            default: r = word;
        endcase
        return r;
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store.
    // w = cycles the bus withholds mem_req_ready, d = cycles before the response.
    task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] ex,
                          input logic [31:0] rs2, input logic [4:0] rd, input logic rwen,
                          input int w, input int d, input logic [31:0] rdata,
                          input logic [31:0] pc);
        logic        ren, wen, mem, illegal, mis, bad, exp_err, exp_rfwen;
        logic [1:0]  a;
        logic [31:0] exp_res, exp_wdata, exp_addr;
        logic [3:0]  exp_wstrb;
        int          n_req, n_rsp;

        ren = (kind == 1);
        wen = (kind == 2);
        mem = ren | wen;
        a   = ex[1:0];
        illegal = 1'b0;
        if (ren) illegal = (f3 == 3) || (f3 == 6) || (f3 == 7);
        if (wen) illegal = (f3 >= 3);
        mis = mem && (((f3 % 4) == 1 && a[0]) || ((f3 % 4) == 2 && a != 0));
        bad = illegal || mis;
        exp_err   = bad || (mem && (w >= T || d >= T));
        exp_res   = ren ? load_model(f3, a, rdata) : ex;
        exp_rfwen = rwen && (rd != 0) && !exp_err;
        exp_addr  = ex & 32'hFFFF_FFFC;
        exp_wstrb = 4'd0;
        exp_wdata = rs2;
        if (wen) begin
            if (f3 == 0) begin exp_wstrb = 4'(1 << a); exp_wdata = (rs2 & 32'hFF) * 32'h0101_0101; end
            if (f3 == 1) begin exp_wstrb = 4'(3 << a); exp_wdata = (rs2 & 32'hFFFF) * 32'h0001_0001; end
            if (f3 == 2) exp_wstrb = 4'hF;
        end

        check("accept_ready", 32'(in_ready), 32'd1);
        in_valid      = 1'b1;
        in_mem_ren    = ren;
        in_mem_wen    = wen;
        in_R_wen      = rwen;
        in_rd         = rd;
        in_funct3     = f3;
        in_ex_result  = ex;
        in_rs2_value  = rs2;
        in_pc         = pc;
        mem_rsp_valid = 1'($urandom);
        mem_rsp_rdata = $urandom;
        step();
        in_valid = 1'b0;
        scramble_inputs();
        mem_rsp_valid = 1'b0;

        if (mem && !bad) begin
            n_req = (w >= T) ? T : w + 1;
            for (int c = 0; c < n_req; c++) begin
                check("req_valid", 32'(mem_req_valid), 32'd1);
                check("req_addr", mem_req_addr, exp_addr);
                check("req_wen", 32'(mem_req_wen), 32'(wen));
                check("req_wstrb", 32'(mem_req_wstrb), 32'(exp_wstrb));
                if (wen) check("req_wdata", mem_req_wdata, exp_wdata);
                check("req_no_done", 32'(wb_done), 32'd0);
                check("req_not_ready", 32'(in_ready), 32'd0);
                mem_req_ready = (c == w);
                // A response coincident with the request handshake must be ignored.
                mem_rsp_valid = (c == w) ? 1'($urandom) : 1'b0;
                mem_rsp_rdata = $urandom;
                step();
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (w < T) begin
                n_rsp = (d >= T) ? T : d + 1;
                for (int c = 0; c < n_rsp; c++) begin
                    check("rsp_req_low", 32'(mem_req_valid), 32'd0);
                    check("rsp_no_done", 32'(wb_done), 32'd0);
                    mem_rsp_valid = (c == d);
                    mem_rsp_rdata = (c == d) ? rdata : $urandom;
                    step();
                end
                mem_rsp_valid = 1'b0;
            end
        end

        // Stray/late response during WB must have no effect.
        mem_rsp_valid = 1'($urandom);
        mem_rsp_rdata = $urandom;
        check("wb_done", 32'(wb_done), 32'd1);
        check("wb_err", 32'(err), 32'(exp_err));
        check("wb_pc", wb_pc, pc);
        check("wb_rf_wen", 32'(rf_wen), 32'(exp_rfwen));
        if (exp_rfwen) begin
            check("wb_rf_waddr", 32'(rf_waddr), 32'(rd));
            check("wb_rf_wdata", rf_wdata, exp_res);
        end
        check("wb_req_low", 32'(mem_req_valid), 32'd0);
        step();
        check("post_done_low", 32'(wb_done), 32'd0);
        check("post_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'd0;
        scramble_inputs();
        repeat (3) step();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_rf_wen", 32'(rf_wen), 32'd0);
        check("rst_wb_done", 32'(wb_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wb_pc", wb_pc, 32'd0);
        reset = 1'b0;
        step();

        // ALU writeback
        run_op(0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 0, 0, 32'd0, 32'h0000_0040);
        // LB from top lane, negative byte
        run_op(1, 3'd0, 32'h0000_0103, 32'd0, 5'd7, 1'b1, 0, 0, 32'h80FF_0000, 32'h0000_0044);
        // SH upper half, request held 3 cycles without ready
        run_op(2, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 5'd9, 1'b1, 3, 1, 32'd0, 32'h0000_0048);
        // misaligned LW
        run_op(1, 3'd2, 32'h0000_0101, 32'd0, 5'd3, 1'b1, 0, 0, 32'd0, 32'h0000_004C);
        // LW with no response -> timeout in RESP
        run_op(1, 3'd2, 32'h0000_0400, 32'd0, 5'd4, 1'b1, 0, 9, 32'h1111_2222, 32'h0000_0050);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hDEAD_BEEF;
        step();
        check("late_rsp_no_done", 32'(wb_done), 32'd0);
        check("late_rsp_ready", 32'(in_ready), 32'd1);
        mem_rsp_valid = 1'b0;
        run_op(1, 3'd2, 32'h0000_0404, 32'd0, 5'd6, 1'b1, 1, 2, 32'hCAFE_F00D, 32'h0000_0054);
        // request-side timeout
        run_op(2, 3'd2, 32'h0000_0500, 32'h1234_5678, 5'd1, 1'b0, 7, 0, 32'd0, 32'h0000_0058);

        // reset while waiting in RESP
        check("r6_ready", 32'(in_ready), 32'd1);
        in_valid     = 1'b1;
        in_mem_ren   = 1'b1;
        in_mem_wen   = 1'b0;
        in_R_wen     = 1'b1;
        in_rd        = 5'd8;
        in_funct3    = 3'd2;
        in_ex_result = 32'h0000_0600;
        in_pc        = 32'h0000_005C;
        step();
        in_valid      = 1'b0;
        mem_req_ready = 1'b1;
        check("r6_req_valid", 32'(mem_req_valid), 32'd1);
        step();
        mem_req_ready = 1'b0;
        step();
        reset         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h5555_AAAA;
        step();
        check("r6_rst_ready", 32'(in_ready), 32'd1);
        check("r6_rst_no_done", 32'(wb_done), 32'd0);
        check("r6_rst_req_low", 32'(mem_req_valid), 32'd0);
        reset = 1'b0;
        step();
        check("r6_after_no_done", 32'(wb_done), 32'd0);
        check("r6_after_ready", 32'(in_ready), 32'd1);
        mem_rsp_valid = 1'b0;
        run_op(1, 3'd4, 32'h0000_0601, 32'd0, 5'd0, 1'b1, 0, 1, 32'h0000_7F00, 32'h0000_0060);

        // randomized ops
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                scramble_inputs();
                mem_rsp_valid = 1'($urandom);
                mem_rsp_rdata = $urandom;
                step();
                check("idle_no_done", 32'(wb_done), 32'd0);
                check("idle_ready", 32'(in_ready), 32'd1);
            end
            run_op($urandom_range(0, 2), 3'($urandom), $urandom, $urandom, 5'($urandom),
                   1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5), $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
